dmem_hs: RTL and testbench
==========================

DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 Parameter DEPTH, default 1024, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  1  access request, qualified by ready.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 a  input  ADDR_W  word address.
REQ-010 wd  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte write enables; bit i gates wd[8i+7:8i].
REQ-012 ready  output  1  block accepts a request this cycle.
REQ-013 rvalid  output  1  rd holds read data this cycle.
REQ-014 rd  output  DATA_W  read data.
REQ-015 err  output  1  one-cycle pulse: accepted access had a >= DEPTH.

Function
REQ-016 State machine states: CLEAR, RUN; reset enters CLEAR with clear pointer 0.
REQ-017 CLEAR: write 0 to word[ptr] each cycle, ptr+1; after ptr = DEPTH-1 is written, go to RUN next cycle; DEPTH cycles total.
REQ-018 ready = 0 in CLEAR, 1 in RUN; requests with ready = 0 are ignored, not queued.
REQ-019 Accepted = req & ready at a rising edge; one access per cycle, back-to-back allowed.
REQ-020 Accepted write, a < DEPTH: each byte lane with be[i] = 1 updated at that edge; other lanes unchanged; be = 0 is a legal no-op write.
REQ-021 Accepted read: rvalid = 1 and rd = word[a] exactly RD_LAT cycles after acceptance; reads are pipelined, one result per cycle.
REQ-022 rd is read-first: a read accepted in the same cycle as a write to the same address returns pre-write data; a read accepted the cycle after a write returns new data.
REQ-023 Accepted access with a >= DEPTH: no memory change; a read still returns rvalid after RD_LAT with rd = 0; err pulses the cycle after acceptance.
REQ-024 rd is 0 whenever rvalid = 0.
REQ-025 Writes never produce rvalid.

Reset
REQ-026 On rst_n = 0 at a rising edge: state CLEAR, ptr 0, ready 0, rvalid 0, rd 0, err 0, read pipeline flushed.
REQ-027 Reset during CLEAR restarts the clear from address 0.
REQ-028 Reset during RUN discards in-flight reads; no rvalid appears for them after reset.
REQ-029 Memory contents are defined only through the clear sequence; no initial-value loading.

Structure
REQ-030 Shared package dmem_pkg holds the state enum (CLEAR, RUN), the legal RD_LAT values, and a byte-lane merge function.
REQ-031 Read latency pipeline (valid + data, depth RD_LAT) is a sub-module dmem_rd_pipe; storage, FSM and write logic stay in dmem_hs.

Verification (DATA_W=32, ADDR_W=8, DEPTH=16)
REQ-032 Release reset, req held 1 -> ready rises exactly 16 cycles after rst_n goes 1; reads of 0..15 all return 0x00000000.
REQ-033 Write a=3 wd=0xAABBCCDD be=0xF, then write a=3 wd=0x11223344 be=0x5, read a=3 -> rd=0xAA22CC44, with rvalid exactly RD_LAT cycles after the read is accepted; run at RD_LAT=1 and 2.
REQ-034 Same-cycle collision: word 5 = 0x1; write a=5 wd=0x2, same-cycle read a=5 -> 0x1; read a=5 next cycle -> 0x2.
REQ-035 Write a=20 wd=0xFFFFFFFF, then read a=20 -> err pulses after each access, rd=0 with rvalid; word 4 (20 mod 16) still 0.
REQ-036 Reset at clear cycle 7 -> ready stays 0 for 16 further cycles; reset with 2 reads in flight (RD_LAT=2) -> no rvalid after reset.
REQ-037 Ten back-to-back reads of a=0..9 after writing a*0x01010101 -> ten consecutive rvalid cycles, data in address order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_hs handshake word memory.
package dmem_pkg;

   typedef enum logic {
      CLEAR,
      RUN
   } state_e;

   // Supported read latencies; other values are clamped into this range.
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic logic [7:0] lane_merge(
      input logic [7:0] old_byte,
      input logic [7:0] new_byte,
      input logic       en
   );
      return en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-latency pipeline: carries a valid flag and data word through RD_LAT stages.
module dmem_rd_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] dat_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] dat_o
);

   logic [RD_LAT-1:0] vld_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];

   // Data is zeroed on entry when invalid, so dat_o is 0 whenever vld_o is 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= vld_i;
         dat_q[0] <= vld_i ? dat_i : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign vld_o = vld_q[RD_LAT-1];
   assign dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/dmem_hs.sv
// Single-port word memory with req/ready handshake, byte enables and a post-reset clear sweep.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   a,
   input  logic [DATA_W-1:0]   wd,
   input  logic [DATA_W/8-1:0] be,
   output logic                ready,
   output logic                rvalid,
   output logic [DATA_W-1:0]   rd,
   output logic                err
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
   localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                        (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept, in_range;
   logic [IDX_W-1:0]  idx, mem_idx;
   logic              mem_we;
   logic [DATA_W-1:0] cur_word, merged, mem_wdata, rd_word;

   assign ready    = (state_q == RUN);
   assign accept   = req && ready && rst_n;
   assign in_range = ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
   assign idx      = a[IDX_W-1:0];
   assign cur_word = mem[idx];
   assign rd_word  = in_range ? cur_word : '0;

   always_comb begin
      merged = '0;
      for (int i = 0; i < LANES; i++)
         merged[8*i +: 8] = lane_merge(cur_word[8*i +: 8], wd[8*i +: 8], be[i]);
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      mem_we    = 1'b0;
      mem_idx   = ptr_q;
      mem_wdata = '0;
      err_d     = accept && !in_range;
      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + IDX_W'(1);
            if (ptr_q == LAST) begin
               state_d = RUN;
               ptr_d   = '0;
            end
         end
         RUN: begin
            if (accept && we && in_range) begin
               mem_we    = 1'b1;
               mem_idx   = idx;
               mem_wdata = merged;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   // NOTE: storage has no reset; its contents are defined by the CLEAR sweep instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
   end

   assign err = err_q;

   dmem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (LAT)
   ) u_rd_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .vld_i (accept && !we),
      .dat_i (rd_word),
      .vld_o (rvalid),
      .dat_o (rd)
   );

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench: two dmem_hs instances (RD_LAT 1 and 2) driven in lockstep against a reference model.
module tb_dmem_hs;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 16;
   localparam int HIST   = 4096;

   logic        clk = 1'b0;
   logic        rst_n, req, we;
   logic [7:0]  a;
   logic [31:0] wd;
   logic [3:0]  be;
   logic        ready1, rvalid1, err1, ready2, rvalid2, err2;
   logic [31:0] rd1, rd2;

   always #5 clk = ~clk;

   dmem_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .a(a), .wd(wd), .be(be),
      .ready(ready1), .rvalid(rvalid1), .rd(rd1), .err(err1)
   );

   dmem_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .a(a), .wd(wd), .be(be),
      .ready(ready2), .rvalid(rvalid2), .rd(rd2), .err(err2)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: word contents, remaining clear cycles, and expected outputs per clock edge.
   bit [31:0] mem_m [DEPTH];
   int        clear_left = DEPTH;
   bit        started = 1'b0;
   int        edge_n = 0;
   bit        exp_vld [2][HIST];
   bit [31:0] exp_rd  [2][HIST];
   bit        exp_err [HIST];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit rn, input bit r, input bit w, input logic [7:0] aa,
                        input logic [31:0] d, input logic [3:0] b);
      bit [31:0] val;
      @(negedge clk);
      rst_n = rn; req = r; we = w; a = aa; wd = d; be = b;
      if (started) begin
         check("ready_l1", 32'(ready1), 32'(clear_left == 0));
         check("ready_l2", 32'(ready2), 32'(clear_left == 0));
      end
      @(posedge clk);
      edge_n++;
      if (!rn) begin
         started    = 1'b1;
         clear_left = DEPTH;
         for (int k = 0; k < 3; k++) begin
            exp_vld[0][edge_n+k] = 1'b0; exp_vld[1][edge_n+k] = 1'b0;
            exp_rd[0][edge_n+k]  = '0;   exp_rd[1][edge_n+k]  = '0;
            exp_err[edge_n+k]    = 1'b0;
         end
      end else if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else if (r) begin
         exp_err[edge_n] = (aa >= DEPTH);
         if (w) begin
            if (aa < DEPTH)
               for (int i = 0; i < 4; i++) if (b[i]) mem_m[aa][8*i +: 8] = d[8*i +: 8];
         end else begin
            val = '0;
            if (aa < DEPTH) val = mem_m[aa];
            exp_vld[0][edge_n]   = 1'b1; exp_rd[0][edge_n]   = val;
            exp_vld[1][edge_n+1] = 1'b1; exp_rd[1][edge_n+1] = val;
         end
      end
      #1;
      if (started) begin
         check("rvalid_l1", 32'(rvalid1), 32'(exp_vld[0][edge_n]));
         check("rd_l1",     rd1,          exp_rd[0][edge_n]);
         check("rvalid_l2", 32'(rvalid2), 32'(exp_vld[1][edge_n]));
         check("rd_l2",     rd2,          exp_rd[1][edge_n]);
         check("err_l1",    32'(err1),    32'(exp_err[edge_n]));
         check("err_l2",    32'(err2),    32'(exp_err[edge_n]));
      end
   endtask

   task automatic release_and_wait(input string tag);
      int cnt;
      cycle(1, 1, 0, 8'd0, '0, '0);
      cnt = 1;
      while (ready1 !== 1'b1 && cnt < 40) begin
         cycle(1, 1, 0, 8'd0, '0, '0);
         cnt++;
      end
      check(tag, 32'(cnt), 32'd16);
   endtask

   initial begin
      int run;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; a = '0; wd = '0; be = '0;

      repeat (3) cycle(0, 0, 0, 8'd0, '0, '0);
      release_and_wait("ready_rise_initial");

      for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 8'(i), '0, '0);
      repeat (2) cycle(1, 0, 0, 8'd0, '0, '0);

      // Byte-lane merge on word 3.
      cycle(1, 1, 1, 8'd3, 32'hAABBCCDD, 4'hF);
      cycle(1, 1, 1, 8'd3, 32'h11223344, 4'h5);
      cycle(1, 1, 0, 8'd3, '0, '0);
      check("merge_rvalid_l1", 32'(rvalid1), 32'd1);
      check("merge_rd_l1", rd1, 32'hAA22CC44);
      check("merge_rvalid_l2_early", 32'(rvalid2), 32'd0);
      cycle(1, 0, 0, 8'd0, '0, '0);
      check("merge_rvalid_l2", 32'(rvalid2), 32'd1);
      check("merge_rd_l2", rd2, 32'hAA22CC44);
      cycle(1, 1, 1, 8'd3, 32'hFFFFFFFF, 4'h0);
      cycle(1, 1, 0, 8'd3, '0, '0);
      check("be_zero_noop", rd1, 32'hAA22CC44);

      // Read-first ordering around word 5.
      cycle(1, 1, 1, 8'd5, 32'h1, 4'hF);
      cycle(1, 1, 0, 8'd5, '0, '0);
      check("collide_old", rd1, 32'h1);
      cycle(1, 1, 1, 8'd5, 32'h2, 4'hF);
      cycle(1, 1, 0, 8'd5, '0, '0);
      check("collide_new", rd1, 32'h2);

      // Out-of-range accesses alias nothing.
      cycle(1, 1, 1, 8'd20, 32'hFFFFFFFF, 4'hF);
      check("oor_write_err", 32'(err1), 32'd1);
      cycle(1, 1, 0, 8'd20, '0, '0);
      check("oor_read_err", 32'(err1), 32'd1);
      check("oor_read_rvalid", 32'(rvalid1), 32'd1);
      check("oor_read_rd", rd1, 32'h0);
      cycle(1, 1, 0, 8'd4, '0, '0);
      check("alias_word4", rd1, 32'h0);
      check("alias_err", 32'(err1), 32'd0);

      // Back-to-back reads in address order.
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 8'(i), 32'(i) * 32'h01010101, 4'hF);
      run = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, 0, 8'(i), '0, '0);
         if (rvalid1 === 1'b1 && rd1 === 32'(i) * 32'h01010101) run++;
      end
      check("b2b_run_l1", 32'(run), 32'd10);
      repeat (2) cycle(1, 0, 0, 8'd0, '0, '0);

      // Random traffic, including out-of-range addresses and idle cycles.
      for (int n = 0; n < 300; n++)
         cycle(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 19)), 32'($urandom), 4'($urandom_range(0, 15)));
      repeat (2) cycle(1, 0, 0, 8'd0, '0, '0);

      // Reset with reads in flight.
      cycle(1, 1, 0, 8'd3, '0, '0);
      cycle(1, 1, 0, 8'd5, '0, '0);
      cycle(0, 1, 0, 8'd6, '0, '0);
      check("flush_rvalid_l2", 32'(rvalid2), 32'd0);
      cycle(0, 0, 0, 8'd0, '0, '0);
      check("flush_rvalid_l2_late", 32'(rvalid2), 32'd0);

      // Reset part-way through the clear sweep restarts it.
      repeat (7) cycle(1, 1, 0, 8'd0, '0, '0);
      cycle(0, 1, 0, 8'd0, '0, '0);
      release_and_wait("ready_rise_restart");
      cycle(1, 1, 0, 8'd3, '0, '0);
      check("cleared_word3", rd1, 32'h0);
      repeat (2) cycle(1, 0, 0, 8'd0, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
